muldiv_issue_ctrl: RTL and testbench

Sequences the iterative multiply/divide unit that sits beside the EX-stage ALU. It accepts an M-extension op from Execute and drives load/step strobes to the unit. It holds the pipeline through the hazard unit's stall/flush network for the operation's duration, then requests and waits for the shared register-file writeback port. It is the single owner of the muldiv datapath's control.

---
 rtl/muldiv_issue_ctrl_pkg.sv | 20 ++
 rtl/muldiv_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared definitions for the multiply/divide issue controller:
// FSM state encoding and the M-extension funct3 op selects.
package muldiv_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_issue_ctrl.sv
// Issue/sequencing control for the iterative multiply/divide unit beside
// the EX-stage ALU. Loads the unit, steps it ITER times, holds the pipeline
// meanwhile, then requests the shared writeback port and waits for a grant.
// Optional build macro: MD_EARLY_OUT_EN (early_done ends RUN immediately).
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_e,
    input  logic [2:0] funct3_e,
    input  logic [4:0] rd_e,
    input  logic       kill,
    input  logic       wb_grant,
    input  logic       early_done,
    output logic       md_load,
    output logic       md_step,
    output logic [2:0] md_op,
    output logic       stall_md,
    output logic       busy,
    output logic       wb_req,
    output logic [4:0] wb_rd
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    md_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       md_op_r;
    logic [4:0]       wb_rd_r;
    logic             wb_req_r;
    logic             busy_r;

    logic             accept_s;
    logic             early_s;
    logic             last_s;
    logic             md_load_s;
    logic             md_step_s;
    logic             stall_s;

`ifdef MD_EARLY_OUT_EN
    assign early_s = early_done;
`else
    // Early completion is not honoured in this build; the input is only sunk.
    logic unused_early_s;
    assign early_s        = 1'b0;
    assign unused_early_s = early_done;
`endif

    assign accept_s = (state_r == ST_IDLE) && start_e && !kill;
    assign last_s   = (cnt_r == CNT_LAST) || early_s;

    // Same-cycle strobes to the unit and the stall into the hazard network.
    always_comb begin
        md_load_s = 1'b0;
        md_step_s = 1'b0;
        stall_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                md_load_s = accept_s;
                stall_s   = accept_s;
            end
            ST_RUN: begin
                md_step_s = !kill && !early_s;
                stall_s   = !kill;
            end
            ST_DONE: begin
                stall_s   = !kill && !wb_grant;
            end
            default: begin
                md_load_s = 1'b0;
                md_step_s = 1'b0;
                stall_s   = 1'b0;
            end
        endcase
    end

    // Sequencing FSM, step counter and registered status/writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            md_op_r  <= 3'b000;
            wb_rd_r  <= 5'd0;
            wb_req_r <= 1'b0;
            busy_r   <= 1'b0;
        end else if (kill) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            wb_req_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_e) begin
                        state_r <= ST_RUN;
                        cnt_r   <= '0;
                        md_op_r <= funct3_e;
                        wb_rd_r <= rd_e;
                        busy_r  <= 1'b1;
                    end
                    wb_req_r <= 1'b0;
                end
                ST_RUN: begin
                    if (last_s) begin
                        // Counter holds here instead of wrapping; rd==0 has no result to write.
                        if (wb_rd_r != 5'd0) begin
                            state_r  <= ST_DONE;
                            wb_req_r <= 1'b1;
                            busy_r   <= 1'b1;
                        end else begin
                            state_r  <= ST_IDLE;
                            wb_req_r <= 1'b0;
                            busy_r   <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (wb_grant) begin
                        state_r  <= ST_IDLE;
                        wb_req_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= '0;
                    wb_req_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign md_load  = md_load_s;
    assign md_step  = md_step_s;
    assign stall_md = stall_s;
    assign md_op    = md_op_r;
    assign wb_rd    = wb_rd_r;
    assign wb_req   = wb_req_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Self-checking bench for muldiv_issue_ctrl: directed steps with a scoreboard
// of pending writeback destinations.
module tb_muldiv_issue_ctrl;
    import muldiv_issue_ctrl_pkg::*;

    localparam int ITER = 32;
`ifdef MD_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start_e, kill, wb_grant, early_done;
    logic [2:0] funct3_e;
    logic [4:0] rd_e;
    logic       md_load, md_step, stall_md, busy, wb_req;
    logic [2:0] md_op;
    logic [4:0] wb_rd;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] sb_q[$];

    always #5 clk = ~clk;

    muldiv_issue_ctrl #(.ITER(ITER)) dut (
        .clk(clk), .rst(rst), .start_e(start_e), .funct3_e(funct3_e),
        .rd_e(rd_e), .kill(kill), .wb_grant(wb_grant), .early_done(early_done),
        .md_load(md_load), .md_step(md_step), .md_op(md_op),
        .stall_md(stall_md), .busy(busy), .wb_req(wb_req), .wb_rd(wb_rd)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_load"},  8'(md_load),  8'd0);
        chk({tag, "_step"},  8'(md_step),  8'd0);
        chk({tag, "_stall"}, 8'(stall_md), 8'd0);
        chk({tag, "_busy"},  8'(busy),     8'd0);
        chk({tag, "_wbreq"}, 8'(wb_req),   8'd0);
    endtask

    // Full operation from start to writeback; caller is at a negedge.
    task automatic op_run(input logic [4:0] rd, input logic [2:0] f3,
                          input int grant_wait, input int early_at);
        int last;
        logic [4:0] exp_rd;
        last = (EARLY_EN && early_at > 0) ? early_at : ITER;
        start_e = 1'b1; funct3_e = f3; rd_e = rd; kill = 1'b0;
        wb_grant = 1'b0; early_done = 1'b0;
        #1;
        chk("c0_load",  8'(md_load),  8'd1);
        chk("c0_stall", 8'(stall_md), 8'd1);
        chk("c0_busy",  8'(busy),     8'd0);
        chk("c0_step",  8'(md_step),  8'd0);
        if (rd != 5'd0) sb_q.push_back(rd);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            start_e    = (c < last) ? 1'b1 : 1'b0;   // stalled op still presented
            funct3_e   = 3'(c);                        // must not be recaptured
            rd_e       = 5'(c + 1);
            early_done = (c == early_at) ? 1'b1 : 1'b0;
            #1;
            chk("run_step",  8'(md_step),  8'((EARLY_EN && c == early_at) ? 1'b0 : 1'b1));
            chk("run_stall", 8'(stall_md), 8'd1);
            chk("run_load",  8'(md_load),  8'd0);
            chk("run_busy",  8'(busy),     8'd1);
            chk("run_wbreq", 8'(wb_req),   8'd0);
            chk("run_op",    8'(md_op),    8'(f3));
        end
        @(negedge clk);
        start_e = 1'b0; early_done = 1'b0;
        if (rd == 5'd0) begin
            #1;
            chk_idle("rd0_end");
            return;
        end
        for (int w = 0; w <= grant_wait; w++) begin
            wb_grant = (w == grant_wait) ? 1'b1 : 1'b0;
            #1;
            chk("done_wbreq", 8'(wb_req),   8'd1);
            chk("done_busy",  8'(busy),     8'd1);
            chk("done_stall", 8'(stall_md), 8'(!wb_grant));
            chk("done_step",  8'(md_step),  8'd0);
            if (wb_grant) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 8'(sb_q.size()), 8'd1);
                end else begin
                    exp_rd = sb_q.pop_front();
                    chk("wb_rd", 8'(wb_rd), 8'(exp_rd));
                end
            end
            @(negedge clk);
        end
        wb_grant = 1'b0;
        #1;
        chk_idle("after_grant");
    endtask

    // Start an op and advance n cycles without checking; ends at a negedge.
    task automatic start_and_run(input logic [4:0] rd, input logic [2:0] f3, input int n);
        start_e = 1'b1; funct3_e = f3; rd_e = rd; kill = 1'b0;
        wb_grant = 1'b0; early_done = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            start_e = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; start_e = 1'b0; kill = 1'b0; wb_grant = 1'b0;
        early_done = 1'b0; funct3_e = 3'b000; rd_e = 5'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset_op", 8'(md_op), 8'd0);
        chk("reset_rd", 8'(wb_rd), 8'd0);
        @(negedge clk);

        // Basic op with grant held high.
        op_run(5'd5, F3_MUL, 0, 0);
        // Grant withheld for 3 DONE cycles.
        op_run(5'd9, F3_DIVU, 3, 0);
        // rd==0: no writeback at all.
        op_run(5'd0, F3_REM, 0, 0);

        // start_e together with kill in IDLE is not accepted.
        start_e = 1'b1; kill = 1'b1; rd_e = 5'd4; funct3_e = F3_DIV;
        #1;
        chk("kill_idle_load",  8'(md_load),  8'd0);
        chk("kill_idle_stall", 8'(stall_md), 8'd0);
        @(negedge clk);
        start_e = 1'b0; kill = 1'b0;
        #1;
        chk_idle("kill_idle_next");
        @(negedge clk);

        // kill at cycle 10 of RUN, then a new op accepted immediately.
        start_and_run(5'd12, F3_MULH, 10);
        kill = 1'b1;
        #1;
        chk("kill_run_step",  8'(md_step),  8'd0);
        chk("kill_run_stall", 8'(stall_md), 8'd0);
        chk("kill_run_busy",  8'(busy),     8'd1);
        @(negedge clk);
        kill = 1'b0;
        op_run(5'd3, F3_MULHU, 1, 0);

        // Synchronous reset while in DONE.
        start_and_run(5'd20, F3_REMU, ITER + 1);
        #1;
        chk("pre_rst_wbreq", 8'(wb_req), 8'd1);
        chk("pre_rst_rd",    8'(wb_rd),  8'd20);
        chk("pre_rst_op",    8'(md_op),  8'(F3_REMU));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle("post_rst");
        chk("post_rst_op", 8'(md_op), 8'd0);
        chk("post_rst_rd", 8'(wb_rd), 8'd0);
        @(negedge clk);

        // early_done at cycle 4 (honoured only with the early-out build).
        op_run(5'd7, F3_DIV, 0, 4);
        // Early out with rd==0 straight back to IDLE.
        op_run(5'd0, F3_DIVU, 0, 2);

        chk("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
